// File: rtl/fu_alu_pipe_if.sv
// Issue/result handshake bundle between the ALU reservation station, the ALU pipe and the CDB arbiter.
interface fu_alu_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_res;
    logic             out_zero;
    logic             out_overflow;
    logic [TAG_W-1:0] out_tag;

    // The functional unit itself.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_overflow, out_tag
    );

    // Issue side plus result consumer.
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_overflow, out_tag
    );
endinterface

// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit: combinational ALU at the input, then STAGES
// elastic registers carrying result/zero/overflow/tag, with collapsing bubbles and flush.
module fu_alu_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    output logic         busy,
    fu_alu_pipe_if.slave bus
);
    localparam int unsigned SH_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_ADD4 = 4'hB;
    localparam logic [3:0] OP_PASB = 4'hC;

    logic [XLEN-1:0]   alu_res_c;
    logic              alu_ovf_c;
    logic              alu_zero_c;
    logic [SH_W-1:0]   shamt_c;
    logic              accept_c;
    logic [STAGES-1:0] load_c;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [STAGES-1:0] ovf_q, ovf_d;
    logic [XLEN-1:0]   res_q [STAGES];
    logic [XLEN-1:0]   res_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    // ALU datapath evaluated on the incoming operands.
    always_comb begin
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        shamt_c   = bus.in_b[SH_W-1:0];
        case (bus.in_op)
            OP_ADD: begin
                alu_res_c = bus.in_a + bus.in_b;
                alu_ovf_c = (bus.in_a[XLEN-1] == bus.in_b[XLEN-1]) &&
                            (alu_res_c[XLEN-1] != bus.in_a[XLEN-1]);
            end
            OP_SUB: begin
                alu_res_c = bus.in_a - bus.in_b;
                alu_ovf_c = (bus.in_a[XLEN-1] != bus.in_b[XLEN-1]) &&
                            (alu_res_c[XLEN-1] != bus.in_a[XLEN-1]);
            end
            OP_AND:  alu_res_c = bus.in_a & bus.in_b;
            OP_OR:   alu_res_c = bus.in_a | bus.in_b;
            OP_XOR:  alu_res_c = bus.in_a ^ bus.in_b;
            OP_SLL:  alu_res_c = bus.in_a << shamt_c;
            OP_SRL:  alu_res_c = bus.in_a >> shamt_c;
            OP_SLT:  alu_res_c = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            OP_SLTU: alu_res_c = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_SRA:  alu_res_c = $unsigned($signed(bus.in_a) >>> shamt_c);
            OP_ADD4: alu_res_c = bus.in_a + XLEN'(4);
            OP_PASB: alu_res_c = bus.in_b;
            default: alu_res_c = '0;
        endcase
        alu_zero_c = (alu_res_c == '0);
    end

    // A stage may load when it or any stage downstream of it holds a bubble, or the sink is draining.
    always_comb begin
        logic bubble;
        bubble = 1'b0;
        load_c = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            bubble    = bubble | ~v_q[k];
            load_c[k] = bus.out_ready | bubble;
        end
    end

    assign bus.in_ready = ~flush & load_c[0];
    assign accept_c     = bus.in_valid & bus.in_ready;

    // Next-state for the elastic stages; payload only moves with a valid op so stalls hold data stable.
    always_comb begin
        v_d    = v_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        res_d  = res_q;
        tag_d  = tag_q;
        if (load_c[0]) begin
            v_d[0] = accept_c;
            if (accept_c) begin
                res_d[0]  = alu_res_c;
                zero_d[0] = alu_zero_c;
                ovf_d[0]  = alu_ovf_c;
                tag_d[0]  = bus.in_tag;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load_c[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    res_d[k]  = res_q[k-1];
                    zero_d[k] = zero_q[k-1];
                    ovf_d[k]  = ovf_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                end
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    // Stage registers; reset discards every in-flight op and clears payloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            zero_q <= '0;
            ovf_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            res_q  <= res_d;
            tag_q  <= tag_d;
        end
    end

    assign bus.out_valid    = v_q[STAGES-1];
    assign bus.out_res      = res_q[STAGES-1];
    assign bus.out_zero     = zero_q[STAGES-1];
    assign bus.out_overflow = ovf_q[STAGES-1];
    assign bus.out_tag      = tag_q[STAGES-1];
    assign busy             = |v_q;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Self-checking bench for fu_alu_pipe: directed vector table, stall/flush/reset sequences, random traffic.
module tb_fu_alu_pipe;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned STAGES = 2;
    localparam int unsigned TAG_W  = 4;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    fu_alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    fu_alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sbq[$];
    exp_t cur_exp;
    logic [3:0] seen_tags[$];
    int   out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        exp_t   e;
        longint sa, sbv, wide;
        logic [31:0] r;
        logic o;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = 32'h0;
        o   = 1'b0;
        case (op)
            4'h1: begin wide = sa + sbv; r = wide[31:0]; o = (wide != longint'($signed(r))); end
            4'h2: begin wide = sa - sbv; r = wide[31:0]; o = (wide != longint'($signed(r))); end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = a << b[4:0];
            4'h7: r = a >> b[4:0];
            4'h8: r = (sa < sbv) ? 32'd1 : 32'd0;
            4'h9: r = (a < b) ? 32'd1 : 32'd0;
            4'hA: begin wide = sa >>> b[4:0]; r = wide[31:0]; end
            4'hB: r = a + 32'd4;
            4'hC: r = b;
            default: r = 32'h0;
        endcase
        e.res  = r;
        e.zero = (r == 32'h0);
        e.ovf  = o;
        e.tag  = tag;
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on consume; flush/reset discard everything queued.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (!flush && bus.out_valid && bus.out_ready) begin
                seen_tags.push_back(bus.out_tag);
                out_cyc.push_back(cyc);
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 64'(bus.out_tag), 64'hFFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_res",  64'(bus.out_res),      64'(e.res));
                    chk("sb_zero", 64'(bus.out_zero),     64'(e.zero));
                    chk("sb_ovf",  64'(bus.out_overflow), 64'(e.ovf));
                    chk("sb_tag",  64'(bus.out_tag),      64'(e.tag));
                end
            end
            if (flush) sbq.delete();
            else if (bus.in_valid && bus.in_ready) sbq.push_back(cur_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input exp_t e);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        cur_exp      = e;
    endtask

    task automatic drive_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
        drive(op, a, b, tag, model(op, a, b, tag));
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sbq.size() == 0 && !busy) break;
            step();
        end
        @(negedge clk);
        chk("drain_sb_empty", 64'(sbq.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        step();
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[$];
        vec_t v;
        exp_t e;
        int   base, idx, n;
        logic acc, held_set;
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        logic [3:0]  ops4_tag[4];

        bus.in_valid  = 1'b1;
        bus.in_op     = 4'h1;
        bus.in_a      = 32'h11;
        bus.in_b      = 32'h22;
        bus.in_tag    = 4'h5;
        bus.out_ready = 1'b1;
        cur_exp       = '0;

        // 1. Reset with in_valid held high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_out_res",   64'(bus.out_res),   64'd0);
        chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
        chk("rst_out_ovf",   64'(bus.out_overflow), 64'd0);
        chk("rst_out_zero",  64'(bus.out_zero),  64'd0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        @(negedge clk);
        chk("rel_nothing_accepted", 64'(busy), 64'd0);
        chk("rel_no_output", 64'(seen_tags.size()), 64'd0);
        step();

        // 2. ADD overflow with latency check.
        e.res = 32'h8000_0000; e.zero = 1'b0; e.ovf = 1'b1; e.tag = 4'd3;
        drive(4'h1, 32'h7FFF_FFFF, 32'h1, 4'd3, e);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid_after_n", 64'(bus.out_valid), 64'd0);
        chk("lat_busy_after_n",  64'(busy),          64'd1);
        step();
        @(negedge clk);
        chk("lat_valid_at_n2", 64'(bus.out_valid),    64'd1);
        chk("add_res",         64'(bus.out_res),      64'h8000_0000);
        chk("add_ovf",         64'(bus.out_overflow), 64'd1);
        chk("add_zero",        64'(bus.out_zero),     64'd0);
        chk("add_tag",         64'(bus.out_tag),      64'd3);
        step();
        drain();

        // 3. Back-to-back directed vector table.
        vecs.push_back('{4'h2, 32'd5,          32'd5,          32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{4'h8, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{4'h9, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{4'hA, 32'h8000_0000,  32'd4,          32'hF800_0000, 1'b0, 1'b0});
        vecs.push_back('{4'hF, 32'h1234,       32'h5678,       32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{4'h1, 32'd1,          32'd2,          32'h0000_0003, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{4'h3, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0});
        vecs.push_back('{4'h4, 32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0, 1'b0, 1'b0});
        vecs.push_back('{4'h5, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 32'd1,          32'h21,         32'h0000_0002, 1'b0, 1'b0});
        vecs.push_back('{4'h7, 32'h8000_0000,  32'd31,         32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{4'hA, 32'h7FFF_FFFF,  32'd4,          32'h07FF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{4'hB, 32'hFFFF_FFFE,  32'd0,          32'h0000_0002, 1'b0, 1'b0});
        vecs.push_back('{4'hC, 32'd0,          32'hDEAD_BEEF,  32'hDEAD_BEEF, 1'b0, 1'b0});
        vecs.push_back('{4'h0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{4'h1, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{4'hD, 32'h1,          32'h1,          32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{4'h8, 32'd1,          32'hFFFF_FFFF,  32'h0000_0000, 1'b1, 1'b0});
        base = out_cyc.size();
        bus.out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            e.res = v.res; e.zero = v.zero; e.ovf = v.ovf; e.tag = 4'(i + 1);
            drive(v.op, v.a, v.b, 4'(i + 1), e);
            step();
        end
        drain();
        n = out_cyc.size() - base;
        chk("b2b_count", 64'(n), 64'(vecs.size()));
        if (n > 0) chk("b2b_no_gaps", 64'(out_cyc[out_cyc.size()-1] - out_cyc[base]), 64'(n - 1));

        // 4. Capacity and stall stability with out_ready low for 6 cycles.
        ops4_tag = '{4'd9, 4'd10, 4'd11, 4'd12};
        base = out_cyc.size();
        bus.out_ready = 1'b0;
        idx = 0;
        held_set = 1'b0;
        held_res = '0;
        held_tag = '0;
        for (int c = 0; c < 6; c++) begin
            drive_m(4'h1, 32'(100 * (idx + 1)), 32'd7, ops4_tag[idx]);
            @(negedge clk);
            acc = bus.in_ready;
            if (bus.out_valid) begin
                if (!held_set) begin
                    held_set = 1'b1;
                    held_res = bus.out_res;
                    held_tag = bus.out_tag;
                end else begin
                    chk("stall_res_stable", 64'(bus.out_res), 64'(held_res));
                    chk("stall_tag_stable", 64'(bus.out_tag), 64'(held_tag));
                end
            end
            step();
            if (acc) idx++;
        end
        chk("cap_accepts", 64'(idx), 64'd2);
        @(negedge clk);
        chk("cap_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("cap_out_valid",    64'(bus.out_valid), 64'd1);
        chk("cap_head_tag",     64'(bus.out_tag),   64'd9);
        chk("cap_head_res",     64'(bus.out_res),   64'd107);
        step();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 4; c++) begin
            drive_m(4'h1, 32'(100 * (idx + 1)), 32'd7, ops4_tag[idx]);
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (acc) idx++;
        end
        chk("cap_all_accepted", 64'(idx), 64'd4);
        drain();
        n = out_cyc.size() - base;
        chk("cap_out_count", 64'(n), 64'd4);
        if (n > 0) chk("cap_no_gaps", 64'(out_cyc[out_cyc.size()-1] - out_cyc[base]), 64'(n - 1));

        // 5. Flush with two ops in flight and a third presented.
        base = seen_tags.size();
        bus.out_ready = 1'b0;
        drive_m(4'h1, 32'd1, 32'd1, 4'hA);
        step();
        drive_m(4'h1, 32'd2, 32'd2, 4'hB);
        step();
        drive_m(4'h1, 32'd3, 32'd3, 4'hC);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy",      64'(busy),          64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        step();
        bus.out_ready = 1'b1;
        drive_m(4'h1, 32'd2, 32'd3, 4'hD);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_lat_n", 64'(bus.out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("post_flush_lat_n2", 64'(bus.out_valid), 64'd1);
        chk("post_flush_tag",    64'(bus.out_tag),   64'hD);
        chk("post_flush_res",    64'(bus.out_res),   64'd5);
        step();
        drain();
        n = 0;
        for (int i = base; i < seen_tags.size(); i++)
            if (seen_tags[i] inside {4'hA, 4'hB, 4'hC}) n++;
        chk("flushed_tags_seen", 64'(n), 64'd0);
        chk("post_flush_outputs", 64'(seen_tags.size() - base), 64'd1);

        // 6. Asynchronous reset mid-stream.
        base = seen_tags.size();
        bus.out_ready = 1'b0;
        drive_m(4'h5, 32'hF, 32'h3, 4'd8);
        step();
        drive_m(4'h5, 32'hF, 32'h5, 4'd9);
        step();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_busy",      64'(busy),          64'd0);
        chk("async_rst_out_tag",   64'(bus.out_tag),   64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        drive_m(4'hC, 32'd0, 32'hCAFE_F00D, 4'd7);
        step();
        bus.in_valid = 1'b0;
        drain();
        chk("after_rst_outputs", 64'(seen_tags.size() - base), 64'd1);
        if (seen_tags.size() > base) chk("after_rst_tag", 64'(seen_tags[base]), 64'd7);

        // Random traffic with random backpressure against the model.
        base = seen_tags.size();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rb = 32'h7FFF_FFFF;
            drive_m(4'($urandom_range(0, 15)), ra, rb, 4'(i));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) n++;
            step();
        end
        drain();
        chk("rand_out_count", 64'(seen_tags.size() - base), 64'(n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
